// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: owns the PC, issues 1-cycle imem reads,
// queues returned words and hands {instr, pc, pc+4} to decode; redirects flush all stale words.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc;
  logic [31:0]   tag;
  logic          inflight;
  logic [CW-1:0] count;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic          pop;
  logic          push;
  logic [IW-1:0] wr_idx;
  int            used;

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Entry 0 is the registered head; pops shift the rest down one slot.
  assign id_valid  = (count != '0);
  assign id_instr  = q_instr[0];
  assign id_pc     = q_pc[0];
  assign id_pc4    = q_pc[0] + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    pop      = id_valid && id_ready;
    push     = inflight && !redirect_valid;
    wr_idx   = IW'(count - CW'(pop));
    used     = int'(count) + int'(inflight) - int'(pop);
    imem_req = !RESET && !redirect_valid && (used < DEPTH);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc         <= {RESET_PC[31:2], 2'b00};
      tag        <= '0;
      inflight   <= 1'b0;
      count      <= '0;
      q_instr[0] <= 32'h0000_0013;
      q_pc[0]    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc  <= pc + 32'd4;
        tag <= pc;
      end
      if (redirect_valid) begin
        // A word returning now belongs to the old path and is dropped with the queue.
        pc    <= {redirect_pc[31:2], 2'b00};
        count <= '0;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (pop && (i + 1) < int'(count)) begin
            q_instr[i] <= q_instr[i+1];
            q_pc[i]    <= q_pc[i+1];
          end
        end
        if (push) begin
          q_instr[wr_idx] <= imem_rdata;
          q_pc[wr_idx]    <= tag;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  assert property (@(posedge CLK) disable iff (RESET)
    !(push && !pop && count == CW'(DEPTH)));

endmodule
